// File: rtl/key_debounce_pulse_if.sv
// key_debounce_pulse_if
//  Groups the push-button conditioner's signals into one bundle.
//  Signals:
//    KeyN   raw button, active-low, asynchronous and bouncing
//    Pulse  one-cycle enable pulse per accepted press (or auto-repeat)
//    Level  debounced button state, 1 = pressed
//  Modports:
//    master  the side that owns the button and consumes Pulse/Level
//    slave   the conditioner itself
interface key_debounce_pulse_if;
  logic KeyN;
  logic Pulse;
  logic Level;

  modport master (output KeyN, input Pulse, input Level);
  modport slave  (input KeyN, output Pulse, output Level);
endinterface

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
//  Turns a raw, active-low, bouncing push-button into a clean one-cycle
//  enable pulse plus a debounced level. One accepted press gives exactly
//  one Pulse, so it can drive a downstream counter enable directly.
//  Ports:
//    Clock  system clock, rising edge
//    Reset  asynchronous, active-high reset
//    key    key_debounce_pulse_if.slave: KeyN in, Pulse/Level out
//  Parameters:
//    DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change
//    REPEAT_DELAY     held cycles before the first auto-repeat pulse
//    REPEAT_PERIOD    cycles between later auto-repeat pulses
//  Build option:
//    AUTO_REPEAT_EN   when defined, a held key emits repeat pulses; when
//                     undefined, no repeat logic exists at all.
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                 Clock,
  input logic                 Reset,
  key_debounce_pulse_if.slave key
);

  // One counter width serves every count so the repeat option never
  // changes the debounce datapath.
  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_V  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W  = ($clog2(MAX_V) < 1) ? 1 : $clog2(MAX_V);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pulse_reg, pulse_next;
  logic             level_reg, level_next;
  logic             sync1_reg, sync2_reg;
  logic             key_s;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_FIRST_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             rep_first_reg, rep_first_next;  // 1 = still waiting for the initial delay
`endif

  // Two-flop synchronizer; resets to "released" so a key held through
  // reset is debounced again from scratch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key.KeyN;
      sync2_reg <= sync1_reg;
    end
  end

  assign key_s = ~sync2_reg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
      level_reg <= level_next;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else begin
      rep_cnt_reg   <= rep_cnt_next;
      rep_first_reg <= rep_first_next;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    level_next = level_reg;
`ifdef AUTO_REPEAT_EN
    // Held cleared outside PRESSED, so entering PRESSED (first press or
    // return from a release bounce) always restarts the initial delay.
    rep_cnt_next   = '0;
    rep_first_next = 1'b1;
`endif
    case (state_reg)
      IDLE: begin
        level_next = 1'b0;
        if (key_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = PRESSED;
          pulse_next = 1'b1;
          level_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          // Leaving PRESSED suppresses any repeat due this cycle.
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          rep_first_next = rep_first_reg;
          if (rep_cnt_reg == (rep_first_reg ? REP_FIRST_LAST : REP_PERIOD_LAST)) begin
            pulse_next     = 1'b1;
            rep_cnt_next   = '0;
            rep_first_next = 1'b0;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = IDLE;
          level_next = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign key.Pulse = pulse_reg;
  assign key.Level = level_reg;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse
//  Drives key_debounce_pulse with directed and random button activity and
//  compares Pulse/Level every cycle against a run-length reference model:
//  the key is seen two edges late, and the debounced level flips after
//  DEB+1 consecutive sampled edges that disagree with it.
module tb_key_debounce_pulse;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  key_debounce_pulse_if kif();

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .key  (kif)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Reference model state.
  logic m_kd1, m_kd2, m_prev_ks, m_lvl, m_pulse;
  int   m_run, m_held;

  always @(posedge Clock or posedge Reset) begin : ref_model
    logic ks;
    logic lvl_n;
    logic pulse_n;
    int   run_n;
    int   held_n;
    if (Reset) begin
      m_kd1     <= 1'b1;
      m_kd2     <= 1'b1;
      m_prev_ks <= 1'b0;
      m_lvl     <= 1'b0;
      m_pulse   <= 1'b0;
      m_run     <= 0;
      m_held    <= 0;
    end else begin
      ks      = ~m_kd2;
      lvl_n   = m_lvl;
      pulse_n = 1'b0;
      run_n   = 0;
      held_n  = 0;
      if (ks != m_lvl) begin
        run_n = m_run + 1;
        if (run_n == DEB + 1) begin
          lvl_n   = ks;
          run_n   = 0;
          pulse_n = ks;
        end
      end
      // Edges spent pressed after a stable pressed edge (restarts on bounce).
      if (m_lvl && lvl_n && ks && m_prev_ks) begin
        held_n = m_held + 1;
`ifdef AUTO_REPEAT_EN
        if (held_n >= RD && ((held_n - RD) % RP) == 0) pulse_n = 1'b1;
`endif
      end
      m_kd1     <= kif.KeyN;
      m_kd2     <= m_kd1;
      m_prev_ks <= ks;
      m_lvl     <= lvl_n;
      m_pulse   <= pulse_n;
      m_run     <= run_n;
      m_held    <= held_n;
    end
  end

  // Downstream 8-bit counter enabled by Pulse.
  logic [7:0] dn_cnt = 8'd0;
  always @(posedge Clock) if (kif.Pulse === 1'b1) dn_cnt <= dn_cnt + 8'd1;

  // Per-cycle comparison against the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      checks++;
      if (kif.Pulse !== m_pulse) begin
        errors++;
        $display("FAIL model_pulse t=%0t got %b want %b", $time, kif.Pulse, m_pulse);
      end
      checks++;
      if (kif.Level !== m_lvl) begin
        errors++;
        $display("FAIL model_level t=%0t got %b want %b", $time, kif.Level, m_lvl);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic lit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end else begin
      $display("ok   %s t=%0t value %b", name, $time, act);
    end
  endtask

  initial begin
    logic [7:0] base;
    kif.KeyN = 1'b1;

    // 1. reset state, then a clean press
    step(3);
    chk_en = 1'b1;
    lit("reset_pulse", kif.Pulse, 1'b0);
    lit("reset_level", kif.Level, 1'b0);
    Reset = 1'b0;
    step(3);
    kif.KeyN = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      lit($sformatf("t1_pulse_e%0d", i), kif.Pulse, (i == 7));
      lit($sformatf("t1_level_e%0d", i), kif.Level, (i >= 7));
    end

    // 3. release bounce while pressed, then a real release
    kif.KeyN = 1'b1;
    step(2);
    kif.KeyN = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      lit($sformatf("t3_bounce_pulse_%0d", i), kif.Pulse, 1'b0);
      lit($sformatf("t3_bounce_level_%0d", i), kif.Level, 1'b1);
    end
    kif.KeyN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      lit($sformatf("t3_rel_level_e%0d", i), kif.Level, (i < 7));
    end

    // 2. press bounces shorter than the debounce window
    for (int r = 0; r < 5; r++) begin
      kif.KeyN = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step(1);
        lit("t2_pulse", kif.Pulse, 1'b0);
      end
      kif.KeyN = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step(1);
        lit("t2_level", kif.Level, 1'b0);
      end
    end
    step(4);

    // 4. reset in the middle of press debounce
    kif.KeyN = 1'b0;
    step(5);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      lit("t4_in_reset_pulse", kif.Pulse, 1'b0);
    end
    Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      lit($sformatf("t4_pulse_e%0d", i), kif.Pulse, (i == 7));
    end
    kif.KeyN = 1'b1;
    step(8);

    // 5. ten clean presses advance the downstream counter by ten
    base = dn_cnt;
    for (int p = 0; p < 10; p++) begin
      kif.KeyN = 1'b0;
      step(8);
      kif.KeyN = 1'b1;
      step(8);
    end
    checks++;
    if (8'(dn_cnt - base) !== 8'h0A) begin
      errors++;
      $display("FAIL t5_count got %0h want 0a", 8'(dn_cnt - base));
    end else begin
      $display("ok   t5_count value %0h", 8'(dn_cnt - base));
    end

`ifdef AUTO_REPEAT_EN
    // 6. held key auto-repeats at +10, +13, +16, ...
    kif.KeyN = 1'b0;
    step(7);
    lit("t6_accept_pulse", kif.Pulse, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      step(1);
      lit($sformatf("t6_rep_%0d", k), kif.Pulse, (k >= 10 && ((k - 10) % 3) == 0));
    end
    kif.KeyN = 1'b1;
    step(10);
`endif

    // Random bouncing, holds and occasional resets, checked by the model.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        Reset = 1'b1;
        step($urandom_range(1, 2));
        Reset = 1'b0;
      end
      kif.KeyN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) step($urandom_range(8, 24));
      else step($urandom_range(1, 6));
    end
    kif.KeyN = 1'b1;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
